// File: rtl/hh_row_filter3.sv
// hh_row_filter3
//   Horizontal 3-tap [1,2,1]/4 smoothing filter over a 16-bit pixel token
//   stream, one output token per input token, row edges replicated.
//   Sits directly downstream of the HH3 pass-through stage.
//
// Optional feature macro: HH_ROW_FILTER3_ROUND_EN
//   defined   -> f(sum) = (sum + 2) >> 2 (round half up)
//   undefined -> f(sum) = sum >> 2       (truncate)
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   In1_DATA/SEND/COUNT   upstream token (COUNT ignored)
//   In1_ACK               combinational consume strobe
//   Out1_DATA/SEND/COUNT  registered downstream token, one-cycle strobe
//   Out1_RDY              downstream can accept a token
//   Out1_ACK              downstream ack (unused)
module hh_row_filter3 #(
  parameter int IMG_WIDTH = 512,
  parameter int COL_W     = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] In1_DATA,
  input  logic        In1_SEND,
  input  logic [15:0] In1_COUNT,
  output logic        In1_ACK,
  output logic [15:0] Out1_DATA,
  output logic        Out1_SEND,
  output logic [15:0] Out1_COUNT,
  input  logic        Out1_RDY,
  input  logic        Out1_ACK
);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [15:0]      p_prev2_q, p_prev2_d;
  logic [15:0]      p_prev1_q, p_prev1_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_send_q, out_send_d;
  logic [15:0]      out_count_q, out_count_d;
  logic             fire_s;
  logic [17:0]      sum_mid_s;
  logic [17:0]      sum_edge_s;
  logic             unused_ok;

  assign unused_ok = ^{In1_COUNT, Out1_ACK};

  // Scale an 18-bit tap sum back to a 16-bit pixel.
  function automatic logic [15:0] filt(input logic [17:0] sum);
    logic [17:0] adj;
`ifdef HH_ROW_FILTER3_ROUND_EN
    adj = sum + 18'd2;
`else
    adj = sum;
`endif
    return adj[17:2];
  endfunction

  // Interior tap sum and right-edge sum (last pixel counted three times).
  always_comb begin
    sum_mid_s  = {2'b00, p_prev2_q} + {1'b0, p_prev1_q, 1'b0} + {2'b00, In1_DATA};
    sum_edge_s = {2'b00, p_prev2_q} + {1'b0, p_prev1_q, 1'b0} + {2'b00, p_prev1_q};
  end

  // Next-state, consume and emit decisions.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    p_prev2_d   = p_prev2_q;
    p_prev1_d   = p_prev1_q;
    out_data_d  = out_data_q;   // data holds after the strobe
    out_send_d  = 1'b0;
    out_count_d = 16'h0;
    fire_s      = 1'b0;
    case (state_q)
      FIRST: begin
        // Left edge: load both taps with the first pixel, nothing to emit yet.
        if (In1_SEND) begin
          fire_s    = 1'b1;
          p_prev2_d = In1_DATA;
          p_prev1_d = In1_DATA;
          col_d     = COL_W'(1);
          state_d   = RUN;
        end else begin
          state_d = FIRST;
        end
      end
      RUN: begin
        // The ~out_send_q term limits the rate to one token per two cycles.
        if (In1_SEND && Out1_RDY && !out_send_q) begin
          fire_s      = 1'b1;
          out_send_d  = 1'b1;
          out_data_d  = filt(sum_mid_s);
          out_count_d = 16'h1;
          p_prev2_d   = p_prev1_q;
          p_prev1_d   = In1_DATA;
          if (col_q == LAST_COL) begin
            state_d = FLUSH;
            col_d   = '0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (Out1_RDY && !out_send_q) begin
          out_send_d  = 1'b1;
          out_data_d  = filt(sum_edge_s);
          out_count_d = 16'h1;
          state_d     = FIRST;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = FIRST;
        col_d   = '0;
      end
    endcase
  end

  // Consume strobe, suppressed while in reset.
  always_comb begin
    In1_ACK = fire_s & ~RESET;
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= FIRST;
      col_q       <= '0;
      p_prev2_q   <= 16'h0;
      p_prev1_q   <= 16'h0;
      out_data_q  <= 16'h0;
      out_send_q  <= 1'b0;
      out_count_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      p_prev2_q   <= p_prev2_d;
      p_prev1_q   <= p_prev1_d;
      out_data_q  <= out_data_d;
      out_send_q  <= out_send_d;
      out_count_q <= out_count_d;
    end
  end

  assign Out1_DATA  = out_data_q;
  assign Out1_SEND  = out_send_q;
  assign Out1_COUNT = out_count_q;

endmodule

// File: tb/tb_hh_row_filter3.sv
// Directed bench for hh_row_filter3: one instance with 4-pixel rows, one with
// 2-pixel rows. Emitted tokens are collected into queues and compared with
// hand-computed rows.
module tb_hh_row_filter3;

  logic        clk = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Instance A: IMG_WIDTH = 4
  logic        rst_a = 1'b1;
  logic [15:0] a_data = 16'h0;
  logic        a_send = 1'b0;
  logic        a_rdy = 1'b1;
  logic        a_ack;
  logic [15:0] a_odata;
  logic        a_osend;
  logic [15:0] a_ocount;
  logic [15:0] qa[$];

  // Instance B: IMG_WIDTH = 2
  logic        rst_b = 1'b1;
  logic [15:0] b_data = 16'h0;
  logic        b_send = 1'b0;
  logic        b_ack;
  logic [15:0] b_odata;
  logic        b_osend;
  logic [15:0] b_ocount;
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  hh_row_filter3 #(.IMG_WIDTH(4), .COL_W(16)) dut_a (
    .CLK(clk), .RESET(rst_a),
    .In1_DATA(a_data), .In1_SEND(a_send), .In1_COUNT(16'h1), .In1_ACK(a_ack),
    .Out1_DATA(a_odata), .Out1_SEND(a_osend), .Out1_COUNT(a_ocount),
    .Out1_RDY(a_rdy), .Out1_ACK(1'b0)
  );

  hh_row_filter3 #(.IMG_WIDTH(2), .COL_W(16)) dut_b (
    .CLK(clk), .RESET(rst_b),
    .In1_DATA(b_data), .In1_SEND(b_send), .In1_COUNT(16'h1), .In1_ACK(b_ack),
    .Out1_DATA(b_odata), .Out1_SEND(b_osend), .Out1_COUNT(b_ocount),
    .Out1_RDY(1'b1), .Out1_ACK(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Collect emitted tokens; COUNT must be 1 on every emit.
  always @(negedge clk) begin
    if (!rst_a && a_osend) begin
      qa.push_back(a_odata);
      chk("a_count", {16'h0, a_ocount}, 32'd1);
    end
    if (!rst_b && b_osend) begin
      qb.push_back(b_odata);
      chk("b_count", {16'h0, b_ocount}, 32'd1);
    end
  end

  // Offer one pixel to A until it is consumed (bounded), then drop SEND.
  task automatic send_a(input logic [15:0] px);
    int n;
    n = 0;
    a_send = 1'b1;
    a_data = px;
    #1;
    while (a_ack !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a_ack_wait", {31'h0, a_ack}, 32'd1);
    @(posedge clk); #1;
    a_send = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] px);
    int n;
    n = 0;
    b_send = 1'b1;
    b_data = px;
    #1;
    while (b_ack !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_ack_wait", {31'h0, b_ack}, 32'd1);
    @(posedge clk); #1;
    b_send = 1'b0;
  endtask

  task automatic chk_row_a(input string tag, input logic [15:0] e[4]);
    chk({tag, "_n"}, qa.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk(tag, (i < qa.size()) ? {16'h0, qa[i]} : 32'hFFFF_FFFF, {16'h0, e[i]});
    end
    qa.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held while upstream offers a token: no consume, no emit.
    a_send = 1'b1;
    a_data = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_ack", {31'h0, a_ack}, 32'd0);
      chk("rst_send", {31'h0, a_osend}, 32'd0);
    end
    chk("rst_data", {16'h0, a_odata}, 32'd0);
    chk("rst_count", {16'h0, a_ocount}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("first_ack", {31'h0, a_ack}, 32'd1);
    @(posedge clk); #1;
    a_send = 1'b0;
    chk("first_no_emit", {31'h0, a_osend}, 32'd0);

    // Basic row 4,8,12,16 (first pixel consumed above).
    send_a(16'd8);
    send_a(16'd12);
    send_a(16'd16);
    idle(8);
    chk_row_a("basic", '{16'd5, 16'd8, 16'd12, 16'd15});

    // Rounding row 0,0,3,0.
    send_a(16'd0);
    send_a(16'd0);
    send_a(16'd3);
    send_a(16'd0);
    idle(8);
`ifdef HH_ROW_FILTER3_ROUND_EN
    chk_row_a("round", '{16'd0, 16'd1, 16'd2, 16'd1});
`else
    chk_row_a("round", '{16'd0, 16'd0, 16'd1, 16'd0});
`endif

    // Backpressure: stall 10 cycles after the 2nd pixel.
    send_a(16'd8);
    send_a(16'd16);
    a_rdy = 1'b0;
    a_send = 1'b1;
    a_data = 16'd24;
    for (int i = 0; i < 10; i++) begin
      chk("stall_ack", {31'h0, a_ack}, 32'd0);
      @(posedge clk); #1;
    end
    chk("stall_emits", qa.size(), 32'd1);
    a_rdy = 1'b1;
    send_a(16'd24);
    send_a(16'd32);
    idle(8);
    chk_row_a("bp", '{16'd10, 16'd16, 16'd24, 16'd30});

    // Two 2-pixel rows on B: saturation extreme, then no carry-over.
    send_b(16'd65535);
    send_b(16'd65535);
    send_b(16'd0);
    send_b(16'd100);
    idle(8);
    chk("b_n", qb.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] eb[4];
      eb = '{16'd65535, 16'd65535, 16'd25, 16'd75};
      chk("rowb", (i < qb.size()) ? {16'h0, qb[i]} : 32'hFFFF_FFFF, {16'h0, eb[i]});
    end

    // Mid-row reset on A: partial row discarded, next token is column 0.
    send_a(16'd50);
    send_a(16'd60);
    rst_a = 1'b1;
    idle(2);
    chk("mrst_send", {31'h0, a_osend}, 32'd0);
    chk("mrst_data", {16'h0, a_odata}, 32'd0);
    rst_a = 1'b0;
    qa.delete();
    #1;
    send_a(16'd1);
    send_a(16'd1);
    send_a(16'd1);
    send_a(16'd1);
    idle(8);
    chk_row_a("mrst", '{16'd1, 16'd1, 16'd1, 16'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hh_row_filter3.md
Name: hh_row_filter3

Overview:
- Streaming actor sitting directly downstream of the HH3 pass-through stage in the visual-saliency pipeline.
- Consumes the 16-bit pixel token stream and applies a horizontal 3-tap [1,2,1]/4 smoothing filter per image row.
- Replicates the row's first and last pixels at the row edges.
- Emits exactly one filtered token per input token, using the same SEND/ACK/RDY/COUNT token interface as its neighbours.

Parameters:
- IMG_WIDTH, 512, pixels per row; legal range 2..65535.
- COL_W, 16, width of the column counter; must satisfy 2^COL_W >= IMG_WIDTH.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset; asynchronous, active-high.
- In1_DATA  in  16  input pixel, unsigned.
- In1_SEND  in  1  upstream token valid.
- In1_COUNT  in  16  upstream token count; ignored.
- In1_ACK  out  1  combinational one-cycle consume strobe.
- Out1_DATA  out  16  filtered pixel, registered.
- Out1_SEND  out  1  registered one-cycle emit strobe.
- Out1_COUNT  out  16  tokens per emit; constant 16'h1 while Out1_SEND=1, 0 otherwise.
- Out1_RDY  in  1  downstream can accept a token.
- Out1_ACK  in  1  downstream ack; unused.

Behaviour:
- Clocking and reset:
  - Clock CLK.
  - Reset RESET, asynchronous, active-high; all state registers are cleared on RESET.
  - Reset values: state=FIRST, col=0, p_prev2=0, p_prev1=0, Out1_SEND=0, Out1_DATA=0, Out1_COUNT=0; In1_ACK=0 while RESET=1.
- Internal state:
  - col: column counter.
  - p_prev2, p_prev1: the two previously consumed pixels.
  - 3-state FSM: FIRST, RUN, FLUSH.
- Consume rule, FIRST: fire = In1_SEND. No emit is produced on this consume.
- Consume rule, RUN: fire = In1_SEND & Out1_RDY & ~Out1_SEND.
- In1_ACK = fire (same cycle).
- Throughput: at most one token every 2 cycles in RUN.
- FIRST, on fire:
  - p_prev2 <= In1_DATA; p_prev1 <= In1_DATA (left-edge replicate); col <= 1; go to RUN.
- RUN, on fire (x = In1_DATA):
  - sum = p_prev2 + 2*p_prev1 + x, 18-bit unsigned.
  - Next cycle: Out1_SEND=1, Out1_DATA=f(sum), Out1_COUNT=1.
  - Shift: p_prev2 <= p_prev1; p_prev1 <= x.
  - If col == IMG_WIDTH-1: go to FLUSH, col <= 0. Otherwise col <= col+1.
- FLUSH: no consume (In1_ACK=0).
  - When Out1_RDY & ~Out1_SEND: emit f(p_prev2 + 3*p_prev1) (right-edge replicate), then go to FIRST.
- Out1_SEND, Out1_DATA and Out1_COUNT are valid for exactly one cycle; they deassert the next cycle and Out1_DATA holds its value.
- Latency:
  - Pixel c's output is emitted one cycle after pixel c+1 is consumed.
  - The last pixel's output is emitted from FLUSH, at least 2 cycles after its consume.
- f(sum) = sum >> 2; no saturation needed, since the maximum 262140 >> 2 = 65535.
- Out1_RDY deasserted: the block stalls in place. In FIRST it still consumes, since no emit is needed.
- In1_SEND dropping mid-row: col and state hold; rows never restart except through RESET.
- RESET mid-row: the partial row is discarded; the next token is treated as column 0.
- Output token order is identical to input order; there is no cross-row contamination because FIRST reloads both taps.

Optional Feature:
- Macro HH_ROW_FILTER3_ROUND_EN.
- Defined: f(sum) = (sum + 2) >> 2, round-half-up. The 18-bit sum still suffices (max 262142).
- Undefined: f(sum) = sum >> 2, truncation.
- No other behaviour changes.

Test Plan:
- Reset behaviour: IMG_WIDTH=4, assert RESET while In1_SEND=1 -> In1_ACK=0 and Out1_SEND=0 throughout; after release, the first token is accepted in FIRST.
- Basic row: IMG_WIDTH=4, Out1_RDY=1, pixels 4,8,12,16 -> outputs 5,8,12,15 in order, each with Out1_COUNT=1. Exactly 4 Out1_SEND pulses; the last follows the FLUSH state.
- Rounding: IMG_WIDTH=4, pixels 0,0,3,0.
  - Without macro -> 0,0,1,0.
  - With HH_ROW_FILTER3_ROUND_EN -> 0,1,2,1.
- Backpressure: hold Out1_RDY=0 for 10 cycles after the 2nd pixel, then release.
  - No In1_ACK while stalled.
  - Out1_DATA sequence unchanged; no token lost or duplicated.
- Row boundary and saturation: IMG_WIDTH=2, two rows: 65535,65535 then 0,100.
  - Row 1 outputs -> 65535,65535.
  - Row 2 outputs -> 25,75.
  - No carry-over of row-1 pixels into row 2.
- Mid-row reset: IMG_WIDTH=4, send 2 pixels, pulse RESET, then send 1,1,1,1 -> outputs 1,1,1,1 and col restarts at 0.
